mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the fetch stage (read-only) and the LSU (read/write).
- Fixed latency `MEM_LAT`, fully pipelined: one access per cycle.
- The LSU wins collisions because it is the older instruction. A starvation counter forces a fetch grant after `MAX_WAIT` consecutive losses.
- Sits between `pc_fetch`/`lsu` and a unified RAM. Returns read data tagged to the owner and exposes a fetch stall request to the hazard unit.

Parameters:
- `MEM_LAT`, 1, memory read latency in cycles (legal 1..4).
- `MAX_WAIT`, 3, consecutive denied fetch-request cycles before fetch is forced (legal 1..15).
- `AW`, 32, address width.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_reset` in 1: reset, asynchronous, active-low.
- `i_if_req` in 1: fetch read request, held until granted.
- `i_if_addr` in AW: fetch address.
- `i_if_flush` in 1: kill all outstanding fetch responses.
- `o_if_gnt` out 1: fetch accepted this cycle.
- `o_if_stall` out 1: `i_if_req & ~o_if_gnt`.
- `o_if_rvalid` out 1: fetch read data valid.
- `o_if_rdata` out 32: fetch read data.
- `i_ls_req` in 1: LSU request, held until granted.
- `i_ls_we` in 1: 1 = store, 0 = load.
- `i_ls_addr` in AW: LSU address.
- `i_ls_wdata` in 32: store data.
- `i_ls_bmask` in 4: store byte enables.
- `o_ls_gnt` out 1: LSU accepted this cycle.
- `o_ls_rvalid` out 1: load data valid.
- `o_ls_rdata` out 32: load data.
- `o_mem_req` out 1: memory access this cycle.
- `o_mem_we` out 1: memory write.
- `o_mem_addr` out AW: memory address.
- `o_mem_wdata` out 32: memory write data.
- `o_mem_bmask` out 4: memory byte enables.
- `i_mem_rdata` in 32: read data, valid `MEM_LAT` cycles after a read request.
- `o_starve` out 1: fetch priority currently forced (debug).

Behaviour:

Reset (`~i_reset`):
- Counter, tag pipe and priority flag cleared.
- All outputs 0.
- In-flight responses discarded, none emitted after reset release.

Grant (combinational, same cycle as request):
- `force_if = (wait_cnt >= MAX_WAIT)`.
- `o_ls_gnt = i_ls_req & ~(force_if & i_if_req)`.
- `o_if_gnt = i_if_req & ~o_ls_gnt`.
- At most one grant per cycle.

Memory side:
- `o_mem_req = o_if_gnt | o_ls_gnt`.
- Address, write enable, write data and byte mask come from the granted requester.
- Fetch grant drives `we = 0` and `bmask = 4'hF`.
- When neither is granted, memory outputs are 0.

Starvation counter `wait_cnt`, 4 bits, saturating:
- Increments when `i_if_req & ~o_if_gnt`.
- Clears on `o_if_gnt`, or whenever `i_if_req = 0`.
- `o_starve = force_if`.

Tag pipe (depth `MEM_LAT`):
- Each stage holds `{vld, owner}`, with owner 0 = IF, 1 = LS.
- Stage 0 loads `vld = o_mem_req & ~o_mem_we`. Stores enter no tag and produce no response.
- Every stage shifts every cycle. There is no backpressure.

Responses:
- At the tail stage, `o_if_rvalid = vld & owner==IF` and `o_ls_rvalid = vld & owner==LS`.
- Both `rdata` outputs are driven by `i_mem_rdata`; the consumer qualifies by `rvalid`.
- Read latency is exactly `MEM_LAT` cycles from grant.

Flush:
- `i_if_flush` clears `vld` on every IF-owned tag in the pipe, including the stage being loaded that cycle.
- LS tags are untouched.
- A fetch granted in the flush cycle still accesses memory, but its response is dropped.

Simultaneous events:
- Both requesting with `wait_cnt < MAX_WAIT`: LS granted.
- Both requesting at `MAX_WAIT`: IF granted, counter clears, LS stays pending.
- LS store and IF request in the same cycle follow the same rules.

Request rules:
- Address and data change while a request is pending but not granted: the arbiter samples the current values. Requesters must hold them stable; the arbiter does not check.
- The block is fully pipelined: no FSM states beyond the counter and tag pipe.

Decomposition:
- Shared package `mem_arb_pkg`:
  - `owner_e` (`OWN_IF`, `OWN_LS`)
  - `tag_t` struct `{vld, owner}`
  - `BMASK_FULL = 4'hF`
- One sub-module, `arb_tag_pipe`: parameterised shift register of `tag_t` with selective flush. Grant and counter logic stay in the top module.

Test Plan:
1. IF-only read, `MEM_LAT = 1`, address `0x100`, memory returns `0xDEADBEEF` → `o_if_gnt` same cycle; `o_if_rvalid = 1` with `0xDEADBEEF` one cycle later; `o_ls_rvalid` stays 0.
2. Both request continuously, `MAX_WAIT = 3` → grant sequence LS,LS,LS,IF,LS,LS,LS,IF; `o_starve` high only on the IF-grant cycles; `o_if_stall` high on the LS-grant cycles.
3. LS store, address `0x2004`, data `0x000000AA`, bmask `4'b0001`, with IF idle → memory `we = 1` and `bmask = 0001` in the grant cycle; no `rvalid` is ever produced.
4. `MEM_LAT = 3`: IF reads at cycles 0 and 1, `i_if_flush` at cycle 2, LS read at cycle 2 → no `o_if_rvalid`; `o_ls_rvalid` at cycle 5.
5. `i_reset` driven low with 2 reads in flight (`MEM_LAT = 2`), released next cycle → all outputs 0 during reset; no `rvalid` afterwards; `wait_cnt = 0`.
6. IF requests and drops its request after 2 denied cycles, then re-requests → counter restarts from 0; the forced grant comes only after 3 fresh denials.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/LSU memory port arbiter
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } tag_t;

  localparam logic [3:0] BMASK_FULL = 4'hF;
  localparam int         WAIT_W     = 4;

endpackage

// File: rtl/arb_tag_pipe.sv
// rtl/arb_tag_pipe.sv - fixed-depth response tag shift register with fetch-only flush
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic resetn,
  input  tag_t load_tag,
  input  logic flush,
  output tag_t tail_tag
);

  tag_t [DEPTH-1:0] stage;

  // A flush kills fetch tags wherever they sit, including the one leaving this cycle.
  function automatic tag_t scrub(input tag_t t, input logic kill);
    tag_t r;
    r = t;
    if (kill && (t.owner == OWN_IF)) begin
      r.vld = 1'b0;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage <= '0;
    end else begin
      stage[0] <= scrub(load_tag, flush);
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= scrub(stage[i-1], flush);
      end
    end
  end

  assign tail_tag = scrub(stage[DEPTH-1], flush);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter, LSU priority with fetch anti-starvation
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 3,
  parameter int AW       = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  input  logic          i_if_flush,
  output logic          o_if_gnt,
  output logic          o_if_stall,
  output logic          o_if_rvalid,
  output logic [31:0]   o_if_rdata,
  input  logic          i_ls_req,
  input  logic          i_ls_we,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [31:0]   i_ls_wdata,
  input  logic [3:0]    i_ls_bmask,
  output logic          o_ls_gnt,
  output logic          o_ls_rvalid,
  output logic [31:0]   o_ls_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_bmask,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_starve
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              force_if;
  tag_t              load_tag;
  tag_t              tail_tag;

  // Grants are gated by reset so every output reads 0 while reset is held.
  assign force_if   = (wait_cnt >= MAX_WAIT_V);
  assign o_ls_gnt   = i_reset & i_ls_req & ~(force_if & i_if_req);
  assign o_if_gnt   = i_reset & i_if_req & ~o_ls_gnt;
  assign o_if_stall = i_reset & i_if_req & ~o_if_gnt;
  assign o_starve   = i_reset & force_if;
  assign o_mem_req  = o_if_gnt | o_ls_gnt;

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    if (o_ls_gnt) begin
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_bmask = i_ls_bmask;
    end else if (o_if_gnt) begin
      o_mem_addr  = i_if_addr;
      o_mem_bmask = BMASK_FULL;
    end
  end

  // Counts consecutive denied fetch cycles; any idle fetch cycle restarts the count.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wait_cnt <= '0;
    end else if (!i_if_req || o_if_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != {WAIT_W{1'b1}}) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    load_tag.vld   = o_mem_req & ~o_mem_we;
    load_tag.owner = o_ls_gnt ? OWN_LS : OWN_IF;
  end

  arb_tag_pipe #(
    .DEPTH(MEM_LAT)
  ) u_tag_pipe (
    .clk     (i_clk),
    .resetn  (i_reset),
    .load_tag(load_tag),
    .flush   (i_if_flush),
    .tail_tag(tail_tag)
  );

  assign o_if_rvalid = tail_tag.vld & (tail_tag.owner == OWN_IF);
  assign o_ls_rvalid = tail_tag.vld & (tail_tag.owner == OWN_LS);
  assign o_if_rdata  = i_reset ? i_mem_rdata : 32'h0;
  assign o_ls_rdata  = i_reset ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int MW  = 3;
  localparam int AW  = 32;

  logic          clk;
  logic          i_reset;
  logic          if_req, if_flush, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr;
  logic [31:0]   ls_wdata;
  logic [3:0]    ls_bmask;
  logic          if_gnt, if_stall, if_rvalid, ls_gnt, ls_rvalid, starve;
  logic [31:0]   if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_bmask;

  mem_port_arbiter #(.MEM_LAT(LAT), .MAX_WAIT(MW), .AW(AW)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_gnt(if_gnt), .o_if_stall(if_stall), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .i_ls_bmask(ls_bmask), .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata), .o_starve(starve)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory environment: byte-maskable storage returning reads LAT cycles later.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rdp [LAT] = '{default: '0};
  assign mem_rdata = rdp[LAT-1];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin : mem_env
    logic [31:0] w;
    for (int i = LAT - 1; i > 0; i--) rdp[i] <= rdp[i-1];
    rdp[0] <= (mem_req && !mem_we) ? mem_rd(mem_addr) : 32'h0;
    if (mem_req && mem_we) begin
      w = mem_rd(mem_addr);
      for (int b = 0; b < 4; b++) if (mem_bmask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      mem[mem_addr] = w;
    end
  end

  // Reference model: loss counter plus a scoreboard of pending responses by due cycle.
  typedef struct {
    int          due;
    bit          own_ls;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb[$];
  int          total, bad, cyc, m_wait;
  bit          exp_if_gnt, exp_ls_gnt, exp_starve, exp_if_rv, exp_ls_rv;
  logic [31:0] exp_rdata;

  task automatic run_cycle(input bit ifr, input logic [31:0] ifa, input bit fl, input bit lsr,
                           input bit we, input logic [31:0] lsa, input logic [31:0] wd,
                           input logic [3:0] bm);
    rsp_t keep[$];
    rsp_t r;
    bit   frc;
    if_req = ifr; if_addr = ifa; if_flush = fl;
    ls_req = lsr; ls_we = we; ls_addr = lsa; ls_wdata = wd; ls_bmask = bm;
    frc        = (m_wait >= MW);
    exp_ls_gnt = lsr && !(frc && ifr);
    exp_if_gnt = ifr && !exp_ls_gnt;
    exp_starve = frc;
    if (fl) begin
      foreach (sb[i]) if (sb[i].own_ls) keep.push_back(sb[i]);
      sb = keep;
    end
    exp_if_rv = 0; exp_ls_rv = 0; exp_rdata = 32'h0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      if (r.own_ls) exp_ls_rv = 1; else exp_if_rv = 1;
      exp_rdata = r.data;
    end
    if (exp_ls_gnt && !we) sb.push_back('{cyc + LAT, 1'b1, mem_rd(lsa)});
    if (exp_if_gnt && !fl) sb.push_back('{cyc + LAT, 1'b0, mem_rd(ifa)});
    m_wait = (!ifr || exp_if_gnt) ? 0 : ((m_wait < 15) ? m_wait + 1 : 15);
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    if_req = 1; if_addr = 32'h44; if_flush = 0;
    ls_req = 1; ls_we = 0; ls_addr = 32'h88; ls_wdata = 32'h1234_5678; ls_bmask = 4'hF;
    @(posedge clk);
    #4;
    total++;
    if ({if_gnt, ls_gnt, if_stall, starve, mem_req, mem_we, if_rvalid, ls_rvalid} !== 8'h0) begin
      bad++;
      $display("FAIL reset_flags act=%b exp=00000000",
               {if_gnt, ls_gnt, if_stall, starve, mem_req, mem_we, if_rvalid, ls_rvalid});
    end
    total++;
    if ({mem_addr, mem_wdata, mem_bmask} !== 68'h0) begin
      bad++;
      $display("FAIL reset_mem_bus act=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_bmask);
    end
    total++;
    if ({if_rdata, ls_rdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_rdata act=%h/%h exp=0", if_rdata, ls_rdata);
    end
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    if_req = 0; ls_req = 0;
    sb.delete();
    m_wait = 0;
    cyc = 0;
  endtask

  task automatic test_if_read();
    mem[32'h100] = 32'hDEAD_BEEF;
    run_cycle(1, 32'h100, 0, 0, 0, 0, 0, 0);
    total++;
    if ({if_gnt, ls_gnt, mem_req, mem_we} !== 4'b1010) begin
      bad++;
      $display("FAIL if_read_grant act=%b exp=1010", {if_gnt, ls_gnt, mem_req, mem_we});
    end
    total++;
    if (mem_addr !== 32'h100 || mem_bmask !== 4'hF) begin
      bad++;
      $display("FAIL if_read_bus act=%h/%h exp=00000100/f", mem_addr, mem_bmask);
    end
    tick();
    for (int k = 1; k <= LAT + 1; k++) begin
      idle();
      total++;
      if (if_rvalid !== (k == LAT) || ls_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL if_read_rvalid k=%0d act=%b%b exp=%b0", k, if_rvalid, ls_rvalid, k == LAT);
      end
      if (k == LAT) begin
        total++;
        if (if_rdata !== 32'hDEAD_BEEF) begin
          bad++;
          $display("FAIL if_read_rdata act=%h exp=deadbeef", if_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    bit e;
    for (int i = 0; i < 8 + LAT + 1; i++) begin
      if (i < 8) run_cycle(1, 32'h40 + 4 * i, 0, 1, 0, 32'h80 + 4 * i, 0, 0);
      else idle();
      e = (i < 8) && ((i % (MW + 1)) == MW);
      total++;
      if (i < 8 && {if_gnt, ls_gnt, starve, if_stall} !== {e, !e, e, !e}) begin
        bad++;
        $display("FAIL starve_seq i=%0d act=%b exp=%b", i, {if_gnt, ls_gnt, starve, if_stall},
                 {e, !e, e, !e});
      end
      total++;
      if (if_rvalid !== exp_if_rv || ls_rvalid !== exp_ls_rv ||
          ((exp_if_rv || exp_ls_rv) && if_rdata !== exp_rdata)) begin
        bad++;
        $display("FAIL starve_rsp i=%0d act=%b%b/%h exp=%b%b/%h", i, if_rvalid, ls_rvalid,
                 if_rdata, exp_if_rv, exp_ls_rv, exp_rdata);
      end
      tick();
    end
  endtask

  task automatic test_store();
    run_cycle(0, 0, 0, 1, 1, 32'h2004, 32'h0000_00AA, 4'b0001);
    total++;
    if ({ls_gnt, if_gnt, mem_req, mem_we, mem_bmask} !== 8'b1011_0001) begin
      bad++;
      $display("FAIL store_ctrl act=%b exp=10110001", {ls_gnt, if_gnt, mem_req, mem_we, mem_bmask});
    end
    total++;
    if (mem_addr !== 32'h2004 || mem_wdata !== 32'hAA) begin
      bad++;
      $display("FAIL store_bus act=%h/%h exp=00002004/000000aa", mem_addr, mem_wdata);
    end
    tick();
    for (int k = 1; k <= LAT + 2; k++) begin
      idle();
      total++;
      if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL store_no_rsp k=%0d act=%b%b exp=00", k, if_rvalid, ls_rvalid);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int j = 0; j < 7; j++) begin
      case (j)
        0: run_cycle(1, 32'h300, 0, 0, 0, 0, 0, 0);
        1: run_cycle(1, 32'h304, 0, 0, 0, 0, 0, 0);
        2: run_cycle(0, 0, 1, 1, 0, 32'h308, 0, 0);
        3: run_cycle(1, 32'h30C, 1, 0, 0, 0, 0, 0);
        default: idle();
      endcase
      total++;
      if (if_rvalid !== 1'b0 || ls_rvalid !== (j == 2 + LAT)) begin
        bad++;
        $display("FAIL flush_rsp j=%0d act=%b%b exp=0%b", j, if_rvalid, ls_rvalid, j == 2 + LAT);
      end
      if (j == 2 + LAT) begin
        total++;
        if (ls_rdata !== mem_rd(32'h308)) begin
          bad++;
          $display("FAIL flush_ls_data act=%h exp=%h", ls_rdata, mem_rd(32'h308));
        end
      end
      if (j == 3) begin
        total++;
        if (if_gnt !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h30C) begin
          bad++;
          $display("FAIL flush_fetch_access act=%b%b/%h exp=11/0000030c", if_gnt, mem_req, mem_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    run_cycle(1, 32'h500, 0, 1, 0, 32'h600, 0, 0);
    tick();
    run_cycle(1, 32'h500, 0, 1, 0, 32'h604, 0, 0);
    tick();
    test_reset();
    for (int j = 0; j < 4 + LAT + 1; j++) begin
      if (j < 4) run_cycle(1, 32'h700, 0, 1, 0, 32'h800 + 4 * j, 0, 0);
      else idle();
      total++;
      if (j < 4 && {if_gnt, starve} !== {j == 3, j == 3}) begin
        bad++;
        $display("FAIL rst_counter j=%0d act=%b exp=%b", j, {if_gnt, starve}, {j == 3, j == 3});
      end
      total++;
      if (if_rvalid !== exp_if_rv || ls_rvalid !== exp_ls_rv || (j < LAT && (if_rvalid || ls_rvalid))) begin
        bad++;
        $display("FAIL rst_no_stale j=%0d act=%b%b exp=%b%b", j, if_rvalid, ls_rvalid, exp_if_rv, exp_ls_rv);
      end
      tick();
    end
  endtask

  task automatic test_drop_rerequest();
    bit e;
    for (int j = 0; j < 7 + LAT + 1; j++) begin
      if (j < 7) run_cycle(j != 2, 32'h900, 0, 1, 0, 32'hA00 + 4 * j, 0, 0);
      else idle();
      e = (j == 6);
      total++;
      if (j < 7 && {if_gnt, ls_gnt, starve} !== {e, !e, e}) begin
        bad++;
        $display("FAIL drop_seq j=%0d act=%b exp=%b", j, {if_gnt, ls_gnt, starve}, {e, !e, e});
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit          ifr, lsr, we, fl;
    logic [31:0] ifa, lsa, wd, e_addr, e_wd;
    logic [3:0]  bm, e_bm;
    for (int n = 0; n < 400 + LAT + 1; n++) begin
      ifr = (n < 400) && ($urandom % 4 != 0);
      lsr = (n < 400) && ($urandom % 3 != 0);
      we  = $urandom % 2;
      fl  = (n < 400) && ($urandom % 12 == 0);
      ifa = {26'h0, 4'($urandom), 2'b00};
      lsa = {26'h0, 4'($urandom), 2'b00};
      wd  = $urandom;
      bm  = 4'($urandom);
      run_cycle(ifr, ifa, fl, lsr, we, lsa, wd, bm);
      e_addr = exp_ls_gnt ? lsa : (exp_if_gnt ? ifa : 32'h0);
      e_wd   = exp_ls_gnt ? wd : 32'h0;
      e_bm   = exp_ls_gnt ? bm : (exp_if_gnt ? 4'hF : 4'h0);
      total++;
      if ({if_gnt, ls_gnt, if_stall, starve, mem_req, mem_we} !==
          {exp_if_gnt, exp_ls_gnt, ifr && !exp_if_gnt, exp_starve, exp_if_gnt || exp_ls_gnt,
           exp_ls_gnt && we}) begin
        bad++;
        $display("FAIL rand_ctrl n=%0d act=%b exp=%b", n, {if_gnt, ls_gnt, if_stall, starve, mem_req, mem_we},
                 {exp_if_gnt, exp_ls_gnt, ifr && !exp_if_gnt, exp_starve, exp_if_gnt || exp_ls_gnt,
                  exp_ls_gnt && we});
      end
      total++;
      if (mem_addr !== e_addr || mem_wdata !== e_wd || mem_bmask !== e_bm) begin
        bad++;
        $display("FAIL rand_bus n=%0d act=%h/%h/%h exp=%h/%h/%h", n, mem_addr, mem_wdata, mem_bmask,
                 e_addr, e_wd, e_bm);
      end
      total++;
      if (if_rvalid !== exp_if_rv || ls_rvalid !== exp_ls_rv ||
          (exp_if_rv && if_rdata !== exp_rdata) || (exp_ls_rv && ls_rdata !== exp_rdata)) begin
        bad++;
        $display("FAIL rand_rsp n=%0d act=%b%b/%h/%h exp=%b%b/%h", n, if_rvalid, ls_rvalid, if_rdata,
                 ls_rdata, exp_if_rv, exp_ls_rv, exp_rdata);
      end
      tick();
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; m_wait = 0;
    test_reset();
    test_if_read();
    test_starvation();
    test_store();
    test_flush();
    test_reset_inflight();
    test_drop_rerequest();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
